lwb_pipe: RTL

Parametrised load-writeback delay pipe for the 32-bit RISC-V core, sitting between the Writeback stage and the register-file write port. It holds loaded data and its destination register for DEPTH cycles, so a late-returning data memory can be retimed onto the register file. Two combinational lookup ports forward in-flight load data to register-read consumers. It adds stall, flush, x0 suppression and an occupancy count.

---
 rtl/lwb_pipe_if.sv | 34 +++
 rtl/lwb_pipe.sv | 95 +++++++++
 2 files changed

// File: rtl/lwb_pipe_if.sv
// Bundle of request, control, writeback, lookup and occupancy signals for lwb_pipe.
// The master drives requests and lookup addresses; the slave is the delay pipe itself.
interface lwb_pipe_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
);
  localparam int PW = $clog2(DEPTH + 1);

  logic            we_in;
  logic [4:0]      rd_in;
  logic [XLEN-1:0] data_in;
  logic            stall;
  logic            flush;
  logic            we_out;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] data_out;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_hit;
  logic            rs2_hit;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [PW-1:0]   pending;

  modport master (
    output we_in, rd_in, data_in, stall, flush, rs1_addr, rs2_addr,
    input  we_out, rd_out, data_out, rs1_hit, rs2_hit, rs1_data, rs2_data, pending
  );

  modport slave (
    input  we_in, rd_in, data_in, stall, flush, rs1_addr, rs2_addr,
    output we_out, rd_out, data_out, rs1_hit, rs2_hit, rs1_data, rs2_data, pending
  );
endinterface

// File: rtl/lwb_pipe.sv
// Load-writeback delay pipe: retimes load data onto the register-file write port by DEPTH
// cycles, with stall, flush, x0 suppression, youngest-first forwarding and an occupancy count.
module lwb_pipe #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input logic         clk,
  input logic         reset,
  lwb_pipe_if.slave   bus
);
  localparam int PW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][4:0]       rd_q, rd_d;
  logic [DEPTH-1:0][XLEN-1:0]  data_q, data_d;
  logic [PW-1:0]               pending_q, pending_d;

  logic            in_valid;
  logic            retire;
  logic [DEPTH-1:0] match1, match2;
  logic            rs1_hit_c, rs2_hit_c;
  logic [XLEN-1:0] rs1_data_c, rs2_data_c;

  // Writes to x0 enter as bubbles so they can neither write back nor forward.
  assign in_valid = bus.we_in & (bus.rd_in != 5'd0);
  assign retire   = valid_q[DEPTH-1];

  // Next-state: flush beats stall beats advance; rd/data may go stale under flush.
  always_comb begin
    valid_d   = valid_q;
    rd_d      = rd_q;
    data_d    = data_q;
    pending_d = pending_q;
    if (bus.flush) begin
      valid_d   = '0;
      pending_d = '0;
    end else if (!bus.stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      valid_d[0] = in_valid;
      rd_d[0]    = bus.rd_in;
      data_d[0]  = bus.data_in;
      case ({in_valid, retire})
        2'b10:   pending_d = pending_q + PW'(1);
        2'b01:   pending_d = pending_q - PW'(1);
        default: pending_d = pending_q;
      endcase
    end else begin
      pending_d = pending_q;
    end
  end

  // Stage and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    rs1_data_c = '0;
    rs2_data_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match1[k] = valid_q[k] && (rd_q[k] == bus.rs1_addr) && (bus.rs1_addr != 5'd0);
      match2[k] = valid_q[k] && (rd_q[k] == bus.rs2_addr) && (bus.rs2_addr != 5'd0);
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rs1_data_c = match1[k] ? data_q[k] : rs1_data_c;
      rs2_data_c = match2[k] ? data_q[k] : rs2_data_c;
    end
    rs1_hit_c = |match1;
    rs2_hit_c = |match2;
  end

  assign bus.we_out   = valid_q[DEPTH-1];
  assign bus.rd_out   = rd_q[DEPTH-1];
  assign bus.data_out = data_q[DEPTH-1];
  assign bus.pending  = pending_q;
  assign bus.rs1_hit  = rs1_hit_c;
  assign bus.rs2_hit  = rs2_hit_c;
  assign bus.rs1_data = rs1_data_c;
  assign bus.rs2_data = rs2_data_c;
endmodule
